// File: rtl/vfd_pkg.sv
// Shared definitions for the IrDA SIR receiver.
//   - rx_state_e : receiver FSM state encoding
//   - T_*        : tick-offset constants for the 16x oversampled frame
//   - bit_end()  : true on the last tick of a data-bit window
package vfd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] T_START_END  = 8'd7;    // last tick of the start window
  localparam logic [7:0] T_DATA_FIRST = 8'd8;    // first tick of bit 0
  localparam logic [7:0] BIT_TICKS    = 8'd16;   // ticks per bit window
  localparam logic [7:0] T_STOP_FIRST = 8'd136;  // first tick of the stop window
  localparam logic [7:0] T_STOP_LAST  = 8'd151;  // frame decision point
  localparam logic [7:0] T_DATA_LAST  = T_STOP_FIRST - 8'd1;

  // A data window closes on its 16th tick. BIT_TICKS is a power of two,
  // so the offset into the window is just the low nibble.
  function automatic logic bit_end(input logic [7:0] t);
    logic [7:0] rel;
    rel = t - T_DATA_FIRST;
    return rel[3:0] == 4'(BIT_TICKS - 8'd1);
  endfunction

endpackage

// File: rtl/vfd_irda_tickgen.sv
// Free-running oversample tick generator.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   o_tick : one-clk enable, high once every DIV clocks (not a clock)
module vfd_irda_tickgen #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  if (DIV < 2) begin : g_bad_div
    $error("vfd_irda_tickgen: DIV must be >= 2");
  end

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CW'(DIV - 1));
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/vfd_irda_rx.sv
// IrDA SIR receiver: 16x oversampled, a low pulse anywhere in a bit window
// decodes as 0. One byte per frame, LSB first.
//   clk, rst     : system clock, asynchronous active-low reset
//   i_enable     : low holds the FSM in IDLE and aborts any frame in flight
//   i_irda_rxd   : raw receiver output, asynchronous, idle high
//   o_data       : last good byte
//   o_valid      : one-clk strobe, o_data just updated
//   o_frame_err  : one-clk strobe, pulse seen in the stop window
//   o_busy       : FSM is not IDLE
module vfd_irda_rx
  import vfd_pkg::*;
#(
  parameter int f_clkin = 12_000_000,
  parameter int baud    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_irda_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int DIV = f_clkin / (16 * baud);

  logic tick;

  vfd_irda_tickgen #(.DIV(DIV)) u_tickgen (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  // Two-flop synchronizer, reset to the idle (high) line level.
  logic [1:0] sync_q;
  logic       line_low;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], i_irda_rxd};
  end

  assign line_low = ~sync_q[1];

  rx_state_e  state_q, state_d;
  logic [7:0] t_q, t_d, t_n;
  logic [7:0] shreg_q, shreg_d;
  logic       low_q, low_d, acc;   // low sample seen in the current window
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  // t_n is the offset the current tick belongs to; every sample and window
  // decision is judged against it.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    shreg_d = shreg_q;
    low_d   = low_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    t_n     = t_q + 8'd1;
    acc     = low_q | line_low;

    if (!i_enable) begin
      state_d = ST_IDLE;
      low_d   = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (line_low) begin
            state_d = ST_START;
            t_d     = 8'd0;
            low_d   = 1'b0;
          end
        end
        ST_START: begin
          t_d = t_n;
          if (t_n == T_START_END) begin
            state_d = ST_DATA;
            low_d   = 1'b0;
          end
        end
        ST_DATA: begin
          t_d   = t_n;
          low_d = acc;
          if (bit_end(t_n)) begin
            shreg_d = {~acc, shreg_q[7:1]};
            low_d   = 1'b0;
            if (t_n == T_DATA_LAST) state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          t_d   = t_n;
          low_d = acc;
          if (t_n == T_STOP_LAST) begin
            state_d = ST_IDLE;
            low_d   = 1'b0;
            if (acc) begin
              ferr_d = 1'b1;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      t_q     <= 8'd0;
      shreg_q <= 8'd0;
      low_q   <= 1'b0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      shreg_q <= shreg_d;
      low_q   <= low_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vfd_irda_rx.sv
// Bench for vfd_irda_rx. Clock chosen so DIV = 10: one bit = 160 clk,
// 3/16-bit pulse = 30 clk. Stimulus is a line-level IrDA encoder; the model
// is the protocol rule itself: a byte sent cleanly comes back unchanged,
// a pulse in the stop bit period yields a frame error and no data.
module tb_vfd_irda_rx;

  localparam int F_CLK   = 1_536_000;
  localparam int BAUD    = 9600;
  localparam int DIV     = F_CLK / (16 * BAUD);
  localparam int BIT_CLK = 16 * DIV;
  localparam int PW      = 3 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;

  int checks = 0;
  int errors = 0;

  int         n_valid = 0, n_err = 0, n_both = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  vfd_irda_rx #(.f_clkin(F_CLK), .baud(BAUD)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (en),
    .i_irda_rxd  (rxd),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid) begin
      n_valid++;
      got_q.push_back(o_data);
    end
    if (o_frame_err) n_err++;
    if (o_valid && o_frame_err) n_both++;
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL timeout: bench did not finish within 100000 cycles");
    $fatal(1, "timeout");
  end

  task automatic drive_bit(input bit val, input int bitclk, input int pw);
    if (!val) begin
      rxd = 1'b0;
      repeat (pw) @(negedge clk);
      rxd = 1'b1;
      repeat (bitclk - pw) @(negedge clk);
    end else begin
      repeat (bitclk) @(negedge clk);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit (optionally corrupted).
  task automatic send_frame(input logic [7:0] b, input int bitclk, input int pw,
                            input bit stop_pulse);
    drive_bit(1'b0, bitclk, pw);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bitclk, pw);
    drive_bit(!stop_pulse, bitclk, pw);
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("FAIL %s o_data: got %h want 00", tag, o_data); end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL %s o_valid: got %b want 0", tag, o_valid); end
    checks++;
    if (o_frame_err !== 1'b0) begin errors++; $display("FAIL %s o_frame_err: got %b want 0", tag, o_frame_err); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL %s o_busy: got %b want 0", tag, o_busy); end
  endtask

  // Send one clean byte and expect exactly one valid strobe carrying it.
  task automatic expect_byte(input string tag, input logic [7:0] b, input int bitclk);
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(b, bitclk, PW, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 1) begin errors++; $display("FAIL %s valid_count: got %0d want 1", tag, n_valid - v0); end
    checks++;
    if (o_data !== b) begin errors++; $display("FAIL %s o_data: got %h want %h", tag, o_data, b); end
    checks++;
    if (n_err !== e0) begin errors++; $display("FAIL %s frame_err_count: got %0d want 0", tag, n_err - e0); end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; rxd = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check_outputs_zero("reset_released_idle");
  endtask

  task automatic test_single();
    expect_byte("single_a5", 8'hA5, BIT_CLK);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    got_q.delete();
    send_frame(8'h00, BIT_CLK, PW, 1'b0);
    send_frame(8'hFF, BIT_CLK, PW, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b valid_count: got %0d want 2", n_valid - v0); end
    checks++;
    if (got_q.size() < 1 || got_q[0] !== 8'h00) begin
      errors++; $display("FAIL b2b first_byte: got %h want 00", got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    checks++;
    if (got_q.size() < 2 || got_q[1] !== 8'hFF) begin
      errors++; $display("FAIL b2b second_byte: got %h want ff", got_q.size() > 1 ? got_q[1] : 8'hxx);
    end
  endtask

  task automatic test_frame_err();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h3C, BIT_CLK, PW, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (n_err - e0 !== 1) begin errors++; $display("FAIL frame_err count: got %0d want 1", n_err - e0); end
    checks++;
    if (n_valid !== v0) begin errors++; $display("FAIL frame_err valid_count: got %0d want 0", n_valid - v0); end
    checks++;
    if (o_data !== 8'hFF) begin errors++; $display("FAIL frame_err o_data_held: got %h want ff", o_data); end
  endtask

  task automatic test_reset_midframe();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    fork
      send_frame(8'h96, BIT_CLK, PW, 1'b0);
      begin
        repeat (60 * DIV) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_mid busy_before: got %b want 1", o_busy); end
        #2 rst = 1'b0;
        #1 check_outputs_zero("rst_mid_async");
      end
    join
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (n_valid !== v0 || n_err !== e0) begin
      errors++; $display("FAIL rst_mid stale_strobe: got valid %0d err %0d want 0 0", n_valid - v0, n_err - e0);
    end
    expect_byte("rst_mid_next_81", 8'h81, BIT_CLK);
  endtask

  task automatic test_enable_abort();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    fork
      send_frame(8'hE7, BIT_CLK, PW, 1'b0);
      begin
        repeat (40 * DIV) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL abort busy_before: got %b want 1", o_busy); end
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL abort busy_after: got %b want 0", o_busy); end
      end
    join
    en = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (n_valid !== v0 || n_err !== e0) begin
      errors++; $display("FAIL abort strobe: got valid %0d err %0d want 0 0", n_valid - v0, n_err - e0);
    end
    checks++;
    if (o_data !== 8'h81) begin errors++; $display("FAIL abort o_data_held: got %h want 81", o_data); end
    expect_byte("abort_next_5a", 8'h5A, BIT_CLK);
  endtask

  task automatic test_baud_offset();
    expect_byte("baud_minus3_c3", 8'hC3, BIT_CLK - 5);
    expect_byte("baud_plus3_c3",  8'hC3, BIT_CLK + 5);
  endtask

  task automatic test_random();
    int v0, e0;
    logic [7:0] b;
    v0 = n_valid; e0 = n_err;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, $urandom_range(BIT_CLK - 4, BIT_CLK + 4),
                 $urandom_range(DIV + 2, 4 * DIV), 1'b0);
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL random count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random byte%0d: got %h want %h", i, i < got_q.size() ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (n_err !== e0) begin errors++; $display("FAIL random frame_err: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_both !== 0) begin errors++; $display("FAIL valid_and_err_together: got %0d want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_reset_midframe();
    test_enable_abort();
    test_baud_offset();
    test_random();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vfd_irda_rx.md
VFD_IRDA_RX -- requirements
Module: VfD_irda_rx

Interface
REQ-001 Parameter f_clkin, default 12_000_000, is the clk frequency in Hz.
REQ-002 Parameter baud, default 9600, is the IrDA SIR bit rate in bit/s.
REQ-003 clk  input  1  system clock, single clock domain; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_enable  input  1  high: receiver runs; low: FSM held in IDLE, no new frame accepted.
REQ-006 i_irda_rxd  input  1  raw IrDA receiver output, asynchronous, idle high, low pulse encodes a 0 bit.
REQ-007 o_data  output  8  last received byte, LSB first on the line.
REQ-008 o_valid  output  1  single-clk strobe, o_data updated and valid.
REQ-009 o_frame_err  output  1  single-clk strobe, frame ended with a pulse in the stop window; o_data unchanged.
REQ-010 o_busy  output  1  high while FSM is not IDLE.

Function
REQ-011 i_irda_rxd SHALL pass a 2-flop synchronizer before any use; the synchronizer contributes 2 clk latency.
REQ-012 A tick enable SHALL pulse once every DIV clk, DIV = f_clkin/(16*baud) by integer division, giving 78 for the defaults; elaboration SHALL fail if DIV < 2.
REQ-013 The tick counter SHALL be free-running and SHALL never be reset by frame activity.
REQ-014 The FSM SHALL sample the synchronized input only on tick cycles.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on a tick with a low sample while i_enable=1; the tick offset counter t (8 bit) is then cleared to 0.
REQ-017 In START, DATA and STOP, t SHALL increment by one per tick.
REQ-018 START -> DATA when t reaches 7.
REQ-019 Data bit k (k=0..7) SHALL own the window t = 16k+8 .. 16k+23.
REQ-020 Each bit SHALL be 0 if any low sample occurs in its window, else 1.
REQ-021 DATA -> STOP at the end of the bit-7 window (t=135).
REQ-022 The stop window SHALL be t = 136..151.
REQ-023 At t=151 with no low sample in the stop window: o_data <= shift register, o_valid=1 for 1 clk, FSM -> IDLE.
REQ-024 At t=151 with any low sample in the stop window: o_frame_err=1 for 1 clk, o_data held, FSM -> IDLE.
REQ-025 o_valid and o_frame_err SHALL never be high together.
REQ-026 o_valid and o_frame_err SHALL assert on the clk after the t=151 tick.
REQ-027 A low sample on the first tick in IDLE after a frame ends SHALL start a new frame, so back-to-back frames are accepted.
REQ-028 Deasserting i_enable mid-frame SHALL abort the frame to IDLE without o_valid or o_frame_err; o_data is held.
REQ-029 Pulses shorter than one tick period (~6.5 us at defaults) MAY be missed; this is not an error.

Reset
REQ-030 On rst=0, all state SHALL clear asynchronously: FSM=IDLE, t=0, tick counter=0, shift register=0, synchronizer flops=1.
REQ-031 On rst=0, all outputs SHALL clear asynchronously: o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0.
REQ-032 After rst is released mid-frame, the receiver SHALL wait in IDLE for the next low sample; no stale strobe is produced.

Structure
REQ-033 Package VfD_pkg SHALL hold the FSM state encoding and the window constants (8, 16, 136, 151).
REQ-034 The tick generator SHALL be sub-module VfD_irda_tickgen, with parameter DIV, inputs clk/rst, output o_tick as a 1-clk enable; derived clocks are forbidden.
REQ-035 o_data/o_valid SHALL be directly consumable by VfD_counter-style blocks or by LED logic in the iCEstick top.

Verification
REQ-036 Scenario, byte 8'hA5 at 9600 baud with 1.6 us-wide... no, 19.5 us pulses -> exactly one o_valid, o_data=8'hA5, o_frame_err=0.
REQ-037 Scenario, byte 8'h00, then 8'hFF immediately following -> two o_valid strobes, o_data 8'h00 then 8'hFF.
REQ-038 Scenario, byte 8'h3C with an extra pulse at t=144 -> o_frame_err=1 once, o_valid=0, o_data keeps its prior value.
REQ-039 Scenario, rst=0 asserted at t=60 of a frame -> all outputs 0 asynchronously; the next clean 8'h81 frame yields o_data=8'h81.
REQ-040 Scenario, i_enable dropped at t=40 and restored -> no strobe for the aborted frame; the next 8'h5A frame is received correctly.
REQ-041 Scenario, stimulus baud offset of ±3% on 8'hC3 -> o_data=8'hC3, no o_frame_err.
